// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel push-button conditioner with a shared tick prescaler.
// Each channel: 2-flop synchroniser, tick-based debounce, press/release pulses,
// long-press detect and auto-repeat.
//
// Ports:
//   clk     system clock
//   clr     asynchronous reset, active-low
//   btn_in  raw button pins, asynchronous to clk
//   state   debounced level, 1 = pressed
//   down    1-clock pulse on accepted press
//   up      1-clock pulse on accepted release
//   held    level, high while a long press is active
//   rpt     1-clock auto-repeat pulse (first one on entry to held)

module multi_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int TICK_WIDTH   = 10,
    parameter int DB_COUNT     = 16,
    parameter int HOLD_COUNT   = 200,
    parameter int REPEAT_COUNT = 50,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] down,
    output logic [CHANNELS-1:0] up,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] rpt
);

    localparam int DBW = $clog2(DB_COUNT + 1);
    localparam int HW  = $clog2(HOLD_COUNT + 1);
    localparam int RW  = (REPEAT_COUNT > 0) ? $clog2(REPEAT_COUNT + 1) : 1;

    localparam int DB_LAST_I  = DB_COUNT - 1;
    localparam int HLD_LAST_I = HOLD_COUNT - 1;
    localparam int RPT_LAST_I = (REPEAT_COUNT > 0) ? REPEAT_COUNT - 1 : 0;

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_LAST_I);
    localparam logic [HW-1:0]  HLD_LAST = HW'(HLD_LAST_I);
    localparam logic [HW-1:0]  HLD_SAT  = HW'(HOLD_COUNT);
    localparam logic [RW-1:0]  RPT_LAST = RW'(RPT_LAST_I);

    // Pin level that means "released"; sync flops reset to it so a
    // released button produces no event after reset.
    localparam logic REL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD
    } hold_t;

    logic tick;

    generate
        if (TICK_WIDTH == 0) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_tick_pre
            logic [TICK_WIDTH-1:0] pre;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    pre <= '0;
                end else begin
                    pre <= pre + 1'b1;
                end
            end

            assign tick = &pre;
        end
    endgenerate

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic           s1;
            logic           s2;
            logic           p;
            logic           st_q;
            logic           down_q;
            logic           up_q;
            logic           held_q;
            logic           rpt_q;
            logic [DBW-1:0] db_cnt;
            logic [HW-1:0]  hold_cnt;
            logic [RW-1:0]  rpt_cnt;
            hold_t          hs;
            logic           accept;
            logic           rise;
            logic           fall;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    s1 <= REL;
                    s2 <= REL;
                end else begin
                    s1 <= btn_in[i];
                    s2 <= s1;
                end
            end

            // Polarity-corrected synchronised level, 1 = pressed.
            assign p = s2 ^ REL;

            // Change accepted on the tick that completes DB_COUNT
            // consecutive ticks of disagreement.
            assign accept = (p != st_q) && tick && (db_cnt == DB_LAST);
            assign rise   = accept && p;
            assign fall   = accept && !p;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    st_q     <= 1'b0;
                    db_cnt   <= '0;
                    down_q   <= 1'b0;
                    up_q     <= 1'b0;
                    held_q   <= 1'b0;
                    rpt_q    <= 1'b0;
                    hold_cnt <= '0;
                    rpt_cnt  <= '0;
                    hs       <= IDLE;
                end else begin
                    down_q <= 1'b0;
                    up_q   <= 1'b0;
                    rpt_q  <= 1'b0;

                    if (p == st_q) begin
                        db_cnt <= '0;
                    end else if (tick) begin
                        if (db_cnt == DB_LAST) begin
                            st_q   <= p;
                            db_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end

                    // Release takes priority over a hold expiry or
                    // repeat landing on the same tick.
                    if (fall) begin
                        hs       <= IDLE;
                        held_q   <= 1'b0;
                        hold_cnt <= '0;
                        rpt_cnt  <= '0;
                        up_q     <= 1'b1;
                    end else if (rise) begin
                        hs       <= PRESS;
                        hold_cnt <= '0;
                        rpt_cnt  <= '0;
                        down_q   <= 1'b1;
                    end else begin
                        unique case (hs)
                            IDLE: begin
                                hold_cnt <= '0;
                                rpt_cnt  <= '0;
                            end
                            PRESS: begin
                                if (tick) begin
                                    if (hold_cnt == HLD_LAST) begin
                                        hs       <= HELD;
                                        held_q   <= 1'b1;
                                        rpt_q    <= 1'b1;
                                        rpt_cnt  <= '0;
                                        hold_cnt <= HLD_SAT;
                                    end else if (hold_cnt != HLD_SAT) begin
                                        hold_cnt <= hold_cnt + 1'b1;
                                    end
                                end
                            end
                            HELD: begin
                                if (tick && (REPEAT_COUNT > 0)) begin
                                    if (rpt_cnt == RPT_LAST) begin
                                        rpt_q   <= 1'b1;
                                        rpt_cnt <= '0;
                                    end else begin
                                        rpt_cnt <= rpt_cnt + 1'b1;
                                    end
                                end
                            end
                            default: begin
                                hs <= IDLE;
                            end
                        endcase
                    end
                end
            end

            assign state[i] = st_q;
            assign down[i]  = down_q;
            assign up[i]    = up_q;
            assign held[i]  = held_q;
            assign rpt[i]   = rpt_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: scoreboard bench for multi_debouncer.
// Three instances cover repeat/no-repeat and prescaled active-high configs.

module tb_multi_debouncer;

    logic clk;
    logic clr_a, clr_b, clr_c;
    logic [3:0] btn_a, btn_b, btn_c;
    logic [3:0] state_a, down_a, up_a, held_a, rpt_a;
    logic [3:0] state_b, down_b, up_b, held_b, rpt_b;
    logic [3:0] state_c, down_c, up_c, held_c, rpt_c;

    int cyc = 0;
    int n_run = 0;
    int n_fail = 0;
    int q0[$];
    int q1[$];
    int q2[$];

    localparam int K_DN = 0;
    localparam int K_UP = 1;
    localparam int K_RP = 2;

    multi_debouncer #(
        .CHANNELS(4), .TICK_WIDTH(0), .DB_COUNT(4),
        .HOLD_COUNT(8), .REPEAT_COUNT(3), .ACTIVE_LOW(1)
    ) u_a (
        .clk(clk), .clr(clr_a), .btn_in(btn_a), .state(state_a),
        .down(down_a), .up(up_a), .held(held_a), .rpt(rpt_a)
    );

    multi_debouncer #(
        .CHANNELS(4), .TICK_WIDTH(0), .DB_COUNT(4),
        .HOLD_COUNT(8), .REPEAT_COUNT(0), .ACTIVE_LOW(1)
    ) u_b (
        .clk(clk), .clr(clr_b), .btn_in(btn_b), .state(state_b),
        .down(down_b), .up(up_b), .held(held_b), .rpt(rpt_b)
    );

    multi_debouncer #(
        .CHANNELS(4), .TICK_WIDTH(2), .DB_COUNT(4),
        .HOLD_COUNT(8), .REPEAT_COUNT(3), .ACTIVE_LOW(0)
    ) u_c (
        .clk(clk), .clr(clr_c), .btn_in(btn_c), .state(state_c),
        .down(down_c), .up(up_c), .held(held_c), .rpt(rpt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: after posedge n, cyc == n until the next posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int inst, input int c, input int k,
                        input int ch);
        int v;
        v = c * 16 + k * 4 + ch;
        case (inst)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Event code = cyc*16 + kind*4 + ch (kind 0=down 1=up 2=rpt).
    task automatic observe(input int inst, input logic [3:0] dn,
                           input logic [3:0] u, input logic [3:0] r);
        logic b;
        int got;
        int want;
        int sz;
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                b = (k == 0) ? dn[ch] : (k == 1) ? u[ch] : r[ch];
                if (b === 1'b1) begin
                    got = cyc * 16 + k * 4 + ch;
                    n_run++;
                    case (inst)
                        0: sz = q0.size();
                        1: sz = q1.size();
                        default: sz = q2.size();
                    endcase
                    if (sz == 0) begin
                        n_fail++;
                        $display("FAIL pulse_inst%0d: got event %0d, none expected",
                                 inst, got);
                    end else begin
                        case (inst)
                            0: want = q0.pop_front();
                            1: want = q1.pop_front();
                            default: want = q2.pop_front();
                        endcase
                        if (want != got) begin
                            n_fail++;
                            $display("FAIL pulse_inst%0d: got event %0d expected %0d",
                                     inst, got, want);
                        end
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        observe(0, down_a, up_a, rpt_a);
        observe(1, down_b, up_b, rpt_b);
        observe(2, down_c, up_c, rpt_c);
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int r0, c, d, q, t1, u1;
        clr_a = 1'b0;
        clr_b = 1'b0;
        clr_c = 1'b0;
        btn_a = 4'hF;
        btn_b = 4'hF;
        btn_c = 4'h0;
        repeat (3) @(negedge clk);

        chk("rst_a", {state_a, down_a, up_a, held_a, rpt_a}, 0);
        chk("rst_b", {state_b, down_b, up_b, held_b, rpt_b}, 0);
        chk("rst_c", {state_c, down_c, up_c, held_c, rpt_c}, 0);

        clr_a = 1'b1;
        clr_b = 1'b1;
        clr_c = 1'b1;
        r0 = cyc;
        repeat (6) @(negedge clk);
        chk("idle_after_rst", {state_a, state_b, state_c}, 0);

        // Single press/release on A ch0, released before hold expiry.
        c = cyc;
        btn_a[0] = 1'b0;
        d = c + 6;
        push(0, d, K_DN, 0);
        push(0, d + 7, K_UP, 0);
        wait_cyc(d - 1);
        chk("a0_state_early", state_a, 4'b0000);
        wait_cyc(d);
        chk("a0_state_set", state_a, 4'b0001);
        chk("a0_down_hi", down_a, 4'b0001);
        wait_cyc(d + 1);
        btn_a[0] = 1'b1;
        chk("a0_down_lo", down_a, 4'b0000);
        wait_cyc(d + 7);
        chk("a0_released", {state_a, held_a}, 0);
        repeat (4) @(negedge clk);

        // Glitches of 3 clocks on A ch1 must never be accepted.
        for (int g = 0; g < 10; g++) begin
            btn_a[1] = 1'b0;
            repeat (3) @(negedge clk);
            btn_a[1] = 1'b1;
            repeat (3) @(negedge clk);
            chk("a1_glitch", state_a[1], 1'b0);
        end
        repeat (6) @(negedge clk);

        // Long hold on A ch2 with repeat every 3 ticks.
        c = cyc;
        btn_a[2] = 1'b0;
        d = c + 6;
        push(0, d, K_DN, 2);
        for (int j = 0; j < 10; j++) push(0, d + 8 + 3 * j, K_RP, 2);
        push(0, d + 36, K_UP, 2);
        wait_cyc(d + 7);
        chk("a2_held_pre", held_a[2], 1'b0);
        wait_cyc(d + 8);
        chk("a2_held_set", held_a[2], 1'b1);
        wait_cyc(d + 30);
        btn_a[2] = 1'b1;
        wait_cyc(d + 35);
        chk("a2_held_still", held_a[2], 1'b1);
        wait_cyc(d + 36);
        chk("a2_released", {state_a[2], held_a[2]}, 2'b00);
        repeat (5) @(negedge clk);

        // Reset mid-hold on A ch3 with the pin still pressed.
        c = cyc;
        btn_a[3] = 1'b0;
        d = c + 6;
        push(0, d, K_DN, 3);
        push(0, d + 8, K_RP, 3);
        wait_cyc(d + 10);
        chk("a3_held_before_clr", held_a[3], 1'b1);
        clr_a = 1'b0;
        #1;
        chk("a3_clr_outputs", {state_a, down_a, up_a, held_a, rpt_a}, 0);
        @(negedge clk);
        @(negedge clk);
        clr_a = 1'b1;
        q = cyc;
        push(0, q + 6, K_DN, 3);
        push(0, q + 14, K_RP, 3);
        push(0, q + 17, K_RP, 3);
        push(0, q + 20, K_RP, 3);
        push(0, q + 21, K_UP, 3);
        wait_cyc(q + 5);
        chk("a3_state_early", state_a[3], 1'b0);
        wait_cyc(q + 6);
        chk("a3_state_again", state_a[3], 1'b1);
        wait_cyc(q + 13);
        chk("a3_held_pre", held_a[3], 1'b0);
        wait_cyc(q + 14);
        chk("a3_held_set", held_a[3], 1'b1);
        wait_cyc(q + 15);
        btn_a[3] = 1'b1;
        wait_cyc(q + 21);
        chk("a3_released", {state_a[3], held_a[3]}, 2'b00);
        repeat (5) @(negedge clk);

        // No-repeat config: one rpt on entering held, none after.
        c = cyc;
        btn_b[0] = 1'b0;
        d = c + 6;
        push(1, d, K_DN, 0);
        push(1, d + 8, K_RP, 0);
        push(1, d + 46, K_UP, 0);
        wait_cyc(d + 8);
        chk("b0_held_set", held_b[0], 1'b1);
        wait_cyc(d + 40);
        btn_b[0] = 1'b1;
        chk("b0_held_still", held_b[0], 1'b1);
        wait_cyc(d + 46);
        chk("b0_released", {state_b[0], held_b[0]}, 2'b00);
        repeat (5) @(negedge clk);

        // Prescaled active-high: all channels together.
        // Ticks land on edges n with (n - r0) % 4 == 0.
        c = cyc;
        btn_c = 4'hF;
        t1 = c + 2;
        while (((t1 - r0) % 4) != 0) t1++;
        d = t1 + 12;
        u1 = d + 3;
        while (((u1 - r0) % 4) != 0) u1++;
        u1 = u1 + 12;
        for (int ch = 0; ch < 4; ch++) push(2, d, K_DN, ch);
        for (int ch = 0; ch < 4; ch++) push(2, u1, K_UP, ch);
        wait_cyc(d - 1);
        chk("c_state_early", state_c, 4'h0);
        wait_cyc(d);
        chk("c_state_all", state_c, 4'hF);
        wait_cyc(d + 1);
        btn_c = 4'h0;
        wait_cyc(u1 - 1);
        chk("c_state_hold", state_c, 4'hF);
        wait_cyc(u1);
        chk("c_state_rel", state_c, 4'h0);
        repeat (8) @(negedge clk);

        while (q0.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL missing_inst0: got nothing expected %0d",
                     q0.pop_front());
        end
        while (q1.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL missing_inst1: got nothing expected %0d",
                     q1.pop_front());
        end
        while (q2.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL missing_inst2: got nothing expected %0d",
                     q2.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
